// File: rtl/baby_mem_sequencer.sv
// Purpose: sequences Baby core read/write word transactions over the 8-bit host pin bus.
// Latency: request to CMD takes 2 cycles; ack 1 cycle after the final write edge, 2 after the final read edge.
// Backpressure: the core holds its request until ack_o; the host paces bytes by strobe edges, and silence aborts to ERR.
module baby_mem_sequencer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       req_read_i,
    input  logic       req_write_i,
    output logic       ack_o,
    output logic       err_o,
    output logic       busy_o,
    input  logic       host_strobe_i,
    output logic       bus_dir_o,
    output logic [1:0] cmd_o,
    output logic [2:0] byte_phase_o,
    output logic       ptp_a_control_o,
    output logic       ptp_a_reset_o,
    output logic       ptp_b_control_o,
    output logic       ptp_b_reset_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CMD  = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_ERR  = 2'b11;

    // Byte count just before the final data edge, and the count once the word is complete.
    localparam logic [2:0] LAST_DATA = 3'(BYTES_PER_WORD - 1);
    localparam logic [2:0] WORD_FULL = 3'(BYTES_PER_WORD);

    // The counter only needs to reach TIMEOUT_CYCLES-1; a match there means this cycle is the last idle one.
    localparam int         TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic          op_wr;
    logic          strobe_q;
    logic          rst_q;
    logic [2:0]    cnt;
    logic [TW-1:0] tmo_cnt;
    logic          strobe_edge;
    logic          tmo_hit;

    // Strobe rising edge and timeout expiry; an edge in the expiry cycle wins.
    always_comb begin
        strobe_edge = host_strobe_i & ~strobe_q;
        tmo_hit     = (TIMEOUT_CYCLES != 0) && !strobe_edge && (tmo_cnt == TMO_LAST);
    end

    // Transaction FSM; every output is a register updated with the state.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state           <= S_IDLE;
            op_wr           <= 1'b0;
            strobe_q        <= 1'b1;   // a strobe already high at reset must not look like an edge
            rst_q           <= 1'b1;
            cnt             <= 3'd0;
            tmo_cnt         <= '0;
            ack_o           <= 1'b0;
            err_o           <= 1'b0;
            busy_o          <= 1'b0;
            bus_dir_o       <= 1'b0;
            cmd_o           <= CMD_IDLE;
            byte_phase_o    <= 3'd0;
            ptp_a_control_o <= 1'b0;
            ptp_b_control_o <= 1'b0;
            ptp_a_reset_o   <= 1'b1;
            ptp_b_reset_o   <= 1'b1;
        end else begin
            strobe_q        <= host_strobe_i;
            rst_q           <= 1'b0;
            ack_o           <= 1'b0;
            ptp_a_control_o <= 1'b0;
            ptp_b_control_o <= 1'b0;
            // Keep the converters cleared for one more cycle after reset drops.
            ptp_a_reset_o   <= rst_q;
            ptp_b_reset_o   <= rst_q;

            case (state)
                S_IDLE: begin
                    busy_o       <= 1'b0;
                    bus_dir_o    <= 1'b0;
                    cmd_o        <= CMD_IDLE;
                    byte_phase_o <= 3'd0;
                    cnt          <= 3'd0;
                    tmo_cnt      <= '0;
                    if (req_read_i || req_write_i) begin
                        // Read wins when both are raised together.
                        op_wr         <= ~req_read_i;
                        state         <= S_LOAD;
                        err_o         <= 1'b0;
                        busy_o        <= 1'b1;
                        cmd_o         <= req_read_i ? CMD_RD : CMD_WR;
                        ptp_a_reset_o <= 1'b1;
                        ptp_b_reset_o <= 1'b1;
                    end
                end

                S_LOAD: begin
                    state        <= S_CMD;
                    bus_dir_o    <= 1'b1;
                    byte_phase_o <= 3'd0;
                    cnt          <= 3'd0;
                    tmo_cnt      <= '0;
                end

                S_CMD: begin
                    if (strobe_edge) begin
                        tmo_cnt <= '0;
                        if (op_wr) begin
                            // Address byte is out; serialiser moves on to data byte 1.
                            state           <= S_WR;
                            ptp_b_control_o <= 1'b1;
                            byte_phase_o    <= 3'd1;
                        end else begin
                            // Address byte is out; turn the bus round for the host.
                            state     <= S_RD;
                            bus_dir_o <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state     <= S_ERR;
                        ack_o     <= 1'b1;
                        err_o     <= 1'b1;
                        cmd_o     <= CMD_ERR;
                        bus_dir_o <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_RD: begin
                    if (cnt == WORD_FULL) begin
                        // The final assembler pulse went out last cycle.
                        state     <= S_DONE;
                        ack_o     <= 1'b1;
                        bus_dir_o <= 1'b0;
                    end else if (strobe_edge) begin
                        tmo_cnt         <= '0;
                        cnt             <= cnt + 3'd1;
                        byte_phase_o    <= cnt + 3'd1;
                        ptp_a_control_o <= 1'b1;
                    end else if (tmo_hit) begin
                        state     <= S_ERR;
                        ack_o     <= 1'b1;
                        err_o     <= 1'b1;
                        cmd_o     <= CMD_ERR;
                        bus_dir_o <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_WR: begin
                    if (strobe_edge) begin
                        tmo_cnt <= '0;
                        cnt     <= cnt + 3'd1;
                        if (cnt == LAST_DATA) begin
                            // Last data byte taken; nothing left to serialise.
                            state     <= S_DONE;
                            ack_o     <= 1'b1;
                            bus_dir_o <= 1'b0;
                        end else begin
                            ptp_b_control_o <= 1'b1;
                            byte_phase_o    <= cnt + 3'd2;
                        end
                    end else if (tmo_hit) begin
                        state     <= S_ERR;
                        ack_o     <= 1'b1;
                        err_o     <= 1'b1;
                        cmd_o     <= CMD_ERR;
                        bus_dir_o <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_DONE, S_ERR: begin
                    state        <= S_IDLE;
                    busy_o       <= 1'b0;
                    bus_dir_o    <= 1'b0;
                    cmd_o        <= CMD_IDLE;
                    byte_phase_o <= 3'd0;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                    cmd_o  <= CMD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baby_mem_sequencer.sv
// Purpose: directed self-checking bench for baby_mem_sequencer with a short timeout.
// Latency: outputs are sampled 1 ns after each rising clock edge.
// Backpressure: the host strobe is driven directly; every wait is bounded by a cycle budget.
module tb_baby_mem_sequencer;

    logic       clk;
    logic       reset_i;
    logic       req_read_i;
    logic       req_write_i;
    logic       ack_o;
    logic       err_o;
    logic       busy_o;
    logic       host_strobe_i;
    logic       bus_dir_o;
    logic [1:0] cmd_o;
    logic [2:0] byte_phase_o;
    logic       ptp_a_control_o;
    logic       ptp_a_reset_o;
    logic       ptp_b_control_o;
    logic       ptp_b_reset_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_a      = 0;
    int n_b      = 0;
    int n_ack    = 0;

    baby_mem_sequencer #(
        .BYTES_PER_WORD (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .req_read_i      (req_read_i),
        .req_write_i     (req_write_i),
        .ack_o           (ack_o),
        .err_o           (err_o),
        .busy_o          (busy_o),
        .host_strobe_i   (host_strobe_i),
        .bus_dir_o       (bus_dir_o),
        .cmd_o           (cmd_o),
        .byte_phase_o    (byte_phase_o),
        .ptp_a_control_o (ptp_a_control_o),
        .ptp_a_reset_o   (ptp_a_reset_o),
        .ptp_b_control_o (ptp_b_control_o),
        .ptp_b_reset_o   (ptp_b_reset_o)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; sample just after the edge and tally pulse outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ptp_a_control_o) n_a++;
        if (ptp_b_control_o) n_b++;
        if (ack_o)           n_ack++;
    endtask

    // Full transaction: request, LOAD, CMD, address edge plus four data edges, 4 cycles apart.
    task automatic run_txn(input logic rd, input logic wr, input logic exp_wr);
        n_a   = 0;
        n_b   = 0;
        n_ack = 0;
        req_read_i  = rd;
        req_write_i = wr;
        tick();
        check_eq("load_rst_a", ptp_a_reset_o, 1);
        check_eq("load_rst_b", ptp_b_reset_o, 1);
        check_eq("load_busy",  busy_o, 1);
        check_eq("load_cmd",   cmd_o, exp_wr ? 2'b10 : 2'b01);
        check_eq("load_err",   err_o, 0);
        req_read_i  = 1'b0;
        req_write_i = 1'b0;
        tick();
        check_eq("cmd_dir",   bus_dir_o, 1);
        check_eq("cmd_phase", byte_phase_o, 0);
        check_eq("cmd_rst_a", ptp_a_reset_o, 0);
        for (int k = 0; k < 5; k++) begin
            host_strobe_i = 1'b1;
            tick();
            if (exp_wr) begin
                check_eq("wr_dir", bus_dir_o, (k < 4) ? 1 : 0);
                if (k < 4) begin
                    check_eq("wr_pulse", ptp_b_control_o, 1);
                    check_eq("wr_phase", byte_phase_o, k + 1);
                    check_eq("wr_ack0",  ack_o, 0);
                end else begin
                    check_eq("wr_ack",      ack_o, 1);
                    check_eq("wr_no_pulse", ptp_b_control_o, 0);
                end
                if (k == 0) n_b = 0;
            end else begin
                check_eq("rd_dir",   bus_dir_o, 0);
                check_eq("rd_phase", byte_phase_o, k);
                check_eq("rd_pulse", ptp_a_control_o, (k > 0) ? 1 : 0);
                check_eq("rd_ack0",  ack_o, 0);
            end
            tick();
            if (!exp_wr && k == 4) check_eq("rd_ack", ack_o, 1);
            host_strobe_i = 1'b0;
            tick();
            tick();
        end
        check_eq("txn_acks", n_ack, 1);
        check_eq("txn_err",  err_o, 0);
        check_eq("txn_busy", busy_o, 0);
        if (exp_wr) check_eq("wr_pulses", n_b, 3);
        else        check_eq("rd_pulses", n_a, 4);
    endtask

    initial begin
        int waited;
        reset_i       = 1'b1;
        req_read_i    = 1'b0;
        req_write_i   = 1'b0;
        host_strobe_i = 1'b1;
        repeat (3) tick();
        check_eq("rst_ack",   ack_o, 0);
        check_eq("rst_err",   err_o, 0);
        check_eq("rst_busy",  busy_o, 0);
        check_eq("rst_dir",   bus_dir_o, 0);
        check_eq("rst_cmd",   cmd_o, 0);
        check_eq("rst_phase", byte_phase_o, 0);
        check_eq("rst_ctl_a", ptp_a_control_o, 0);
        check_eq("rst_ctl_b", ptp_b_control_o, 0);
        check_eq("rst_rst_a", ptp_a_reset_o, 1);
        check_eq("rst_rst_b", ptp_b_reset_o, 1);
        reset_i = 1'b0;
        tick();
        check_eq("post_rst_a", ptp_a_reset_o, 1);
        check_eq("post_rst_b", ptp_b_reset_o, 1);
        tick();
        check_eq("post2_rst_a", ptp_a_reset_o, 0);
        check_eq("post_busy",   busy_o, 0);
        host_strobe_i = 1'b0;
        tick();

        // Read, write, then both requests together (read wins).
        run_txn(1'b1, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1);
        run_txn(1'b1, 1'b1, 1'b0);

        // Read that stalls after two data bytes: ERR after 8 edge-free cycles.
        n_a = 0;
        req_read_i = 1'b1;
        tick();
        check_eq("to_cmd", cmd_o, 2'b01);
        req_read_i = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            host_strobe_i = 1'b1;
            tick();
            tick();
            host_strobe_i = 1'b0;
            tick();
            tick();
        end
        repeat (4) tick();
        check_eq("to_early_ack", ack_o, 0);
        check_eq("to_early_err", err_o, 0);
        check_eq("to_busy",      busy_o, 1);
        tick();
        check_eq("to_ack", ack_o, 1);
        check_eq("to_err", err_o, 1);
        check_eq("to_cmd_err", cmd_o, 2'b11);
        tick();
        check_eq("to_ack_drop", ack_o, 0);
        check_eq("to_err_hold", err_o, 1);
        check_eq("to_idle_cmd", cmd_o, 0);
        check_eq("to_pulses",   n_a, 2);
        repeat (3) tick();
        check_eq("to_err_sticky", err_o, 1);
        // Next accepted request clears the error (checked at LOAD inside run_txn).
        run_txn(1'b0, 1'b1, 1'b1);

        // Reset in WR after two data edges, strobe held high across reset.
        n_ack = 0;
        req_write_i = 1'b1;
        tick();
        req_write_i = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            host_strobe_i = 1'b1;
            tick();
            tick();
            host_strobe_i = 1'b0;
            tick();
            tick();
        end
        host_strobe_i = 1'b1;
        tick();
        check_eq("mid_pulse", ptp_b_control_o, 1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_eq("mrst_busy",  busy_o, 0);
        check_eq("mrst_dir",   bus_dir_o, 0);
        check_eq("mrst_phase", byte_phase_o, 0);
        check_eq("mrst_rst_a", ptp_a_reset_o, 1);
        check_eq("mrst_rst_b", ptp_b_reset_o, 1);
        tick();
        check_eq("mrst2_rst_a", ptp_a_reset_o, 1);
        check_eq("mrst2_rst_b", ptp_b_reset_o, 1);
        tick();
        check_eq("mrst3_rst_a", ptp_a_reset_o, 0);
        check_eq("mrst_no_ack", n_ack, 0);
        // Strobe still high: a new read must sit in CMD with no edge seen.
        req_read_i = 1'b1;
        tick();
        req_read_i = 1'b0;
        tick();
        tick();
        tick();
        check_eq("phantom_dir",   bus_dir_o, 1);
        check_eq("phantom_phase", byte_phase_o, 0);
        check_eq("phantom_busy",  busy_o, 1);
        waited = 0;
        while (!ack_o && waited < 20) begin
            tick();
            waited++;
        end
        check_eq("cmd_to_ack", ack_o, 1);
        check_eq("cmd_to_err", err_o, 1);
        check_eq("cmd_to_cmd", cmd_o, 2'b11);
        host_strobe_i = 1'b0;
        tick();
        tick();

        // Strobe held high for 10 cycles in RD gives one assembler pulse.
        req_read_i = 1'b1;
        tick();
        check_eq("hold_err_clr", err_o, 0);
        req_read_i = 1'b0;
        tick();
        host_strobe_i = 1'b1;
        tick();
        tick();
        host_strobe_i = 1'b0;
        tick();
        tick();
        n_a = 0;
        host_strobe_i = 1'b1;
        repeat (10) tick();
        check_eq("hold_pulses", n_a, 1);
        host_strobe_i = 1'b0;
        tick();
        tick();
        check_eq("hold_tmo_err", err_o, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
